// File: rtl/tx_byte_scheduler_pkg.sv
// Shared constants for the transmit byte scheduler: frame bytes and FSM encoding.
package tx_byte_scheduler_pkg;

  localparam logic [7:0] LBRACE = 8'h7B;
  localparam logic [7:0] RBRACE = 8'h7D;
  localparam logic [7:0] LF     = 8'h0A;
  localparam logic [7:0] DIGIT0 = 8'h30;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_LOAD      = 3'd1;
  localparam logic [2:0] ST_START     = 3'd2;
  localparam logic [2:0] ST_WAIT_ACK  = 3'd3;
  localparam logic [2:0] ST_WAIT_DONE = 3'd4;
  localparam logic [2:0] ST_GAP       = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE      = ST_IDLE,
    S_LOAD      = ST_LOAD,
    S_START     = ST_START,
    S_WAIT_ACK  = ST_WAIT_ACK,
    S_WAIT_DONE = ST_WAIT_DONE,
    S_GAP       = ST_GAP
  } state_e;

  function automatic logic is_frame_end(input logic [7:0] b);
    return b == LF;
  endfunction

endpackage

// File: rtl/tx_byte_scheduler_fifo.sv
// Byte FIFO with registered full/level; a push while full is ignored even if a pop
// happens in the same cycle, so the drop decision depends only on registered state.
module byte_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [7:0]    din_i,
  output logic [7:0]    dout_o,
  output logic          full_o,
  output logic [AW:0]   level_o
);

  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   level_q, level_d;
  logic          full_q;
  logic          do_push, do_pop;

  assign do_push = push_i && !full_q;
  assign do_pop  = pop_i && (level_q != '0);

  always_comb begin
    level_d = level_q;
    if (do_push && !do_pop)      level_d = level_q + 1'b1;
    else if (!do_push && do_pop) level_d = level_q - 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q <= level_d;
      full_q  <= (level_d == FULL_LVL);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

  assign dout_o  = mem_q[rd_ptr_q];
  assign full_o  = full_q;
  assign level_o = level_q;

endmodule

// File: rtl/tx_byte_scheduler.sv
// Buffers controller bytes and feeds them one at a time to the UART transmitter
// with a start/busy handshake, ack-timeout retry, optional inter-byte gap and LF frame flag.
module tx_byte_scheduler
  import tx_byte_scheduler_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int AW          = 4,
  parameter int GAP_CYCLES  = 0,
  parameter int ACK_TIMEOUT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [7:0]  buf_in,
  output logic        full,
  output logic [AW:0] level,
  output logic        overflow,
  input  logic        tx_busy,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  output logic        frame_done,
  output logic        idle
);

  localparam int AKW = $clog2(ACK_TIMEOUT + 1);
  localparam int GW  = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  state_e         state_q, state_d;
  logic [AKW-1:0] ack_q, ack_d;
  logic [GW-1:0]  gap_q, gap_d;
  logic [7:0]     data_q, data_d;
  logic           fd_q, fd_d;
  logic           ovf_q;
  logic           pop;
  logic [7:0]     head;

  byte_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (wr_en),
    .pop_i   (pop),
    .din_i   (buf_in),
    .dout_o  (head),
    .full_o  (full),
    .level_o (level)
  );

  always_comb begin
    state_d  = state_q;
    ack_d    = ack_q;
    gap_d    = gap_q;
    data_d   = data_q;
    fd_d     = 1'b0;
    pop      = 1'b0;
    tx_start = 1'b0;
    case (state_q)
      S_IDLE: if (level != '0 && !tx_busy) state_d = S_LOAD;
      S_LOAD: begin
        pop     = 1'b1;
        data_d  = head;
        state_d = S_START;
      end
      S_START: begin
        tx_start = 1'b1;
        ack_d    = AKW'(ACK_TIMEOUT);
        state_d  = S_WAIT_ACK;
      end
      // Counter reaching zero re-issues the same byte; retries never give up.
      S_WAIT_ACK: begin
        if (tx_busy) state_d = S_WAIT_DONE;
        else begin
          ack_d = ack_q - 1'b1;
          if (ack_q == AKW'(1)) state_d = S_START;
        end
      end
      S_WAIT_DONE: begin
        if (!tx_busy) begin
          fd_d = is_frame_end(data_q);
          if (GAP_CYCLES == 0) state_d = S_IDLE;
          else begin
            gap_d   = GW'(GAP_CYCLES);
            state_d = S_GAP;
          end
        end
      end
      S_GAP: begin
        gap_d = gap_q - 1'b1;
        if (gap_q == GW'(1)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      ack_q   <= '0;
      gap_q   <= '0;
      data_q  <= 8'h00;
      fd_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      gap_q   <= gap_d;
      data_q  <= data_d;
      fd_q    <= fd_d;
      ovf_q   <= wr_en && full;
    end
  end

  assign tx_data    = data_q;
  assign frame_done = fd_q;
  assign overflow   = ovf_q;
  assign idle       = (state_q == S_IDLE) && (level == '0);

endmodule

// File: tb/tb_tx_byte_scheduler.sv
// Scoreboard bench: pushes queue expected bytes, a transmitter/monitor process
// acknowledges tx_start, and checks order, retries, gap timing and frame_done.
module tb_tx_byte_scheduler;
  import tx_byte_scheduler_pkg::*;

  localparam int DEPTH = 4;
  localparam int AW    = 2;
  localparam int GAP   = 3;
  localparam int ACK   = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic          tx_busy = 1'b0;
  logic [7:0]    buf_in = 8'h00;
  logic          full, overflow, tx_start, frame_done, idle;
  logic [AW:0]   level;
  logic [7:0]    tx_data;

  tx_byte_scheduler #(.DEPTH(DEPTH), .AW(AW), .GAP_CYCLES(GAP), .ACK_TIMEOUT(ACK)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .buf_in(buf_in), .full(full), .level(level),
    .overflow(overflow), .tx_busy(tx_busy), .tx_start(tx_start), .tx_data(tx_data),
    .frame_done(frame_done), .idle(idle)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  logic [7:0] exp_q[$];
  int mode = 0;  // 0 auto-ack, 1 never ack, 2 busy held high
  int n_first = 0, n_retry = 0, n_fd = 0, n_gapchk = 0, n_starts = 0, n_acc = 0;
  bit pending = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Transmitter model and output monitor.
  initial begin : xmt_env
    int ack_wait, busy_left, last_start, fell_at, cyc;
    logic [7:0] cur;
    bit fd_due, gap_armed;
    ack_wait = 0; busy_left = 0; last_start = 0; fell_at = 0; cyc = 0;
    cur = 8'h00; fd_due = 1'b0; gap_armed = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        tx_busy = 1'b0; ack_wait = 0; busy_left = 0; pending = 1'b0;
        fd_due = 1'b0; gap_armed = 1'b0; n_first = 0;
        continue;
      end
      if (frame_done || fd_due) begin
        chk("frame_done", frame_done, fd_due);
        if (frame_done) n_fd++;
      end
      fd_due = 1'b0;
      if (tx_start) begin
        n_starts++;
        if (!pending) begin
          if (exp_q.size() == 0) chk("unexpected_tx_start", tx_start, 0);
          else begin
            cur = exp_q.pop_front();
            chk("tx_data", tx_data, cur);
            n_first++;
            pending = 1'b1;
            if (gap_armed) begin
              chk("gap_to_start", cyc - fell_at, 3 + GAP);
              n_gapchk++;
            end
          end
        end else begin
          chk("retry_data", tx_data, cur);
          chk("retry_period", cyc - last_start, ACK + 1);
          n_retry++;
        end
        gap_armed = 1'b0;
        last_start = cyc;
        if (mode == 0 && ack_wait == 0 && busy_left == 0) ack_wait = $urandom_range(1, 3);
      end
      if (mode == 2) tx_busy = 1'b1;
      else if (ack_wait > 0) begin
        ack_wait--;
        if (ack_wait == 0) begin
          tx_busy = 1'b1;
          busy_left = $urandom_range(2, 6);
        end
      end else if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) begin
          tx_busy = 1'b0;
          pending = 1'b0;
          fd_due = (cur == LF);
          fell_at = cyc;
          gap_armed = (exp_q.size() > 0);
        end
      end else tx_busy = 1'b0;
    end
  end

  task automatic push(input logic [7:0] b, input bit ok);
    wr_en = 1'b1;
    buf_in = b;
    if (ok) begin
      exp_q.push_back(b);
      n_acc++;
    end
    @(negedge clk);
    wr_en = 1'b0;
    chk("overflow", overflow, !ok);
  endtask

  task automatic wait_drain(input string nm);
    int n;
    n = 0;
    while (!(exp_q.size() == 0 && !pending && idle && !tx_busy) && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk(nm, n < 400, 1);
    repeat (3) @(negedge clk);
  endtask

  initial begin : main
    int fd0, f0, r0, r1, g0, s0, peak, n;
    logic [7:0] b;
    logic [7:0] frame [4];
    frame[0] = LBRACE; frame[1] = 8'(DIGIT0 + 8'd3); frame[2] = RBRACE; frame[3] = LF;

    repeat (3) @(negedge clk);
    chk("rst_full", full, 0);
    chk("rst_level", level, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_tx_start", tx_start, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_idle", idle, 1);
    rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("start_after_rst", tx_start, 0);
    end

    // single byte and start latency
    push(8'(DIGIT0 + 8'd3), 1'b1);
    chk("level_after_push", level, 1);
    chk("idle_with_data", idle, 0);
    @(negedge clk); chk("lat_k1", tx_start, 0);
    @(negedge clk); chk("lat_k2", tx_start, 1);
    chk("level_after_pop", level, 0);
    wait_drain("drain_single");
    chk("idle_single", idle, 1);

    // back-to-back frame
    fd0 = n_fd; peak = 0;
    for (int i = 0; i < 4; i++) begin
      push(frame[i], 1'b1);
      if (int'(level) > peak) peak = int'(level);
    end
    repeat (30) begin
      @(negedge clk);
      if (int'(level) > peak) peak = int'(level);
    end
    wait_drain("drain_frame");
    chk("frame_peak", peak, 3);
    chk("frame_done_count", n_fd - fd0, 1);

    // overflow with transmitter held busy
    mode = 2; f0 = n_first;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 6; i++) push(8'(8'hA0 + i), i < 4);
    chk("ovf_level", level, 4);
    chk("ovf_full", full, 1);
    @(negedge clk); chk("ovf_pulse_end", overflow, 0);
    mode = 0;
    wait_drain("drain_ovf");
    chk("ovf_sent", n_first - f0, 4);
    chk("ovf_full_clear", full, 0);

    // no ack: retries every ACK+1 clocks
    mode = 1; r0 = n_retry;
    push(DIGIT0, 1'b1);
    repeat (22) @(negedge clk);
    chk("retry_level", level, 0);
    chk("retry_count", (n_retry - r0) >= 3, 1);
    r1 = n_retry; mode = 0;
    wait_drain("drain_retry");
    chk("retry_stop", (n_retry - r1) <= 1, 1);

    // gap timing between queued bytes
    g0 = n_gapchk;
    push(RBRACE, 1'b1);
    push(LF, 1'b1);
    wait_drain("drain_gap");
    chk("gap_checked", n_gapchk - g0, 1);

    // async reset in the middle of a byte
    for (int i = 0; i < 4; i++) push(frame[i], 1'b1);
    n = 0;
    while (!tx_busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("rst_wait_busy", n < 50, 1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_level", level, 0);
    chk("mid_rst_full", full, 0);
    chk("mid_rst_tx_start", tx_start, 0);
    chk("mid_rst_tx_data", tx_data, 0);
    chk("mid_rst_frame_done", frame_done, 0);
    chk("mid_rst_overflow", overflow, 0);
    chk("mid_rst_idle", idle, 1);
    exp_q.delete();
    n_acc = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    s0 = n_starts;
    repeat (12) @(negedge clk);
    chk("no_start_after_rst", n_starts - s0, 0);
    chk("idle_after_rst", idle, 1);

    // randomized traffic, never exceeding capacity
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 2) == 0 && (n_acc - n_first) < DEPTH) begin
        b = ($urandom_range(0, 3) == 0) ? LF : 8'($urandom);
        push(b, 1'b1);
      end else @(negedge clk);
    end
    wait_drain("drain_random");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/tx_byte_scheduler.md
Name: tx_byte_scheduler

Overview:
Sits between the turn-handling controller and the UART transmitter. It buffers bytes pushed by the controller through its wr_en/buf_in interface, such as the frame sequence 8'h7B, an ASCII digit, 8'h7D, 8'h0A. It then sequences them into the transmitter one at a time using a start/busy handshake. It also flags frame completion on LF and reports overflow, so the game controller never stalls on the serial link.

Parameters:
DEPTH, 16, FIFO entries; power of two, minimum 2.
AW, 4, log2(DEPTH).
GAP_CYCLES, 0, idle clocks inserted after each transmitted byte; 0 means no gap.
ACK_TIMEOUT, 4, clocks to wait for tx_busy after tx_start before retrying; minimum 1.

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
wr_en  in  1  push strobe from the turn controller
buf_in  in  8  byte to push
full  out  1  FIFO holds DEPTH bytes
level  out  AW+1  current FIFO occupancy
overflow  out  1  one-cycle pulse when a push is dropped
tx_busy  in  1  UART transmitter busy
tx_start  out  1  one-cycle request to the transmitter
tx_data  out  8  byte presented to the transmitter; held stable from LOAD until the byte completes
frame_done  out  1  one-cycle pulse after an 8'h0A byte finishes transmitting
idle  out  1  high when the FSM is in IDLE and the FIFO is empty

Behaviour:
- Reset (async assert, sync release): FIFO empty, level=0, FSM in IDLE.
- Output reset values: full=0, overflow=0, tx_start=0, tx_data=8'h00, frame_done=0, idle=1.
- Push: accepted on a clk edge when wr_en=1 and full=0.
- Dropped push: if wr_en=1 and full=1, the byte is dropped and overflow pulses for one cycle. This holds even if a pop happens in the same cycle.
- full and level are registered. A simultaneous push and pop leaves level unchanged.
- FSM states: IDLE, LOAD, START, WAIT_ACK, WAIT_DONE, GAP.
- IDLE: moves to LOAD when level!=0 and tx_busy=0.
- LOAD: pops the FIFO head into tx_data, then moves to START.
- START: tx_start=1 for exactly this cycle. Loads the ack counter with ACK_TIMEOUT, then moves to WAIT_ACK.
- WAIT_ACK:
  - tx_busy=1 moves to WAIT_DONE.
  - Otherwise the counter decrements. At 0 the FSM moves back to START (retry, same tx_data). Retries are unbounded.
- WAIT_DONE: waits for tx_busy=0. Then:
  - if tx_data==8'h0A, frame_done pulses the next cycle;
  - if GAP_CYCLES==0, go to IDLE; otherwise load the gap counter with GAP_CYCLES and go to GAP.
- GAP: decrements each cycle and moves to IDLE when it reaches 1.
- Latency: with an empty FIFO, tx_busy=0 and IDLE, a push sampled at edge k gives tx_start high in the cycle following edge k+2.
- Ordering: bytes are transmitted in strict FIFO order; there is no reordering or duplication except ACK retries.
- Pointers: read and write pointers are AW bits and wrap modulo DEPTH. level counts 0..DEPTH.
- tx_busy high while in IDLE blocks LOAD; no tx_start is issued.
- Reset mid-byte: FSM returns to IDLE and FIFO contents are discarded. tx_start is never asserted during or on the cycle after reset release.

Decomposition:
- Shared package:
  - ASCII constants: LBRACE 8'h7B, RBRACE 8'h7D, LF 8'h0A, DIGIT0 8'h30.
  - FSM state encoding, 3-bit localparams.
- Sub-module byte_fifo: synchronous FIFO with DEPTH/AW parameters, push/pop, registered full/level and async reset. The scheduler FSM, retry counter, gap counter and frame detection stay in the top.

Test Plan:
- Single push 8'h33, tx_busy pulsed high 2 clks after tx_start for 10 clks -> one tx_start with tx_data=8'h33; frame_done stays 0; idle returns to 1.
- Back-to-back pushes 7B,33,7D,0A with transmitter model busy 10 clks per byte -> tx_start four times in that order, level peaks at 3, frame_done pulses once after the 0A byte completes.
- DEPTH=4, tx_busy held high, six pushes on consecutive cycles -> level=4, full=1, overflow pulses on pushes 5 and 6. After releasing tx_busy, exactly the first four bytes are sent.
- tx_busy stuck low after a push of 8'h30 -> tx_start repeats every ACK_TIMEOUT+1 = 5 clks with tx_data=8'h30 and level=0; raising tx_busy stops the retries.
- GAP_CYCLES=3, two bytes queued -> second tx_start occurs exactly 3 clks later than with GAP_CYCLES=0 after the first byte's tx_busy falls.
- rst asserted asynchronously mid-WAIT_DONE with 3 bytes queued -> outputs immediately at reset values, level=0; no tx_start after release until a new push.
